// File: rtl/led_arbiter.sv
// Round-robin LED bank arbiter with minimum hold time and a one-cycle blank on every handoff.
// Optional idle heartbeat on led[0] when LED_ARB_HEARTBEAT_EN is defined.
module led_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned LED_W       = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned IDLE_DIV    = 24
) (
    input  logic                       clk_i,
    input  logic                       resetn_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*LED_W-1:0]   pattern_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [LED_W-1:0]           led_o,
    output logic                       busy_o
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);

    localparam logic [CntW-1:0] HoldMax = CntW'(HOLD_CYCLES);
    localparam logic [IdxW-1:0] LastRst = IdxW'(NUM_REQ - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StGrant = 2'd1;
    localparam logic [1:0] StGap   = 2'd2;

    if (NUM_REQ < 2 || HOLD_CYCLES < 1 || IDLE_DIV < 1) begin : g_param_check
        $error("led_arbiter: parameter out of range");
    end

    logic [1:0]         state_q, state_d;
    logic [IdxW-1:0]    last_q, last_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [LED_W-1:0]   led_q, led_d;

    logic               any_req;
    logic               others_req;
    logic               win_found;
    logic [31:0]        scan;
    logic [IdxW-1:0]    win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic [NUM_REQ-1:0] own_oh;
    logic [LED_W-1:0]   win_pat;
    logic [LED_W-1:0]   own_pat;
    logic [LED_W-1:0]   idle_led;

    assign any_req = |req_i;

    // Scan starts just after the most recent grantee, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan = (32'(last_q) + k) % NUM_REQ;
            if (!win_found && req_i[IdxW'(scan)]) begin
                win_found = 1'b1;
                win_idx   = IdxW'(scan);
            end
        end
    end

    always_comb begin
        win_oh  = '0;
        own_oh  = '0;
        win_pat = '0;
        own_pat = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            win_oh[i] = (IdxW'(i) == win_idx);
            own_oh[i] = (IdxW'(i) == owner_q);
            if (IdxW'(i) == win_idx) win_pat = pattern_i[i*LED_W +: LED_W];
            if (IdxW'(i) == owner_q) own_pat = pattern_i[i*LED_W +: LED_W];
        end
    end

    assign others_req = |(req_i & ~own_oh);

`ifdef LED_ARB_HEARTBEAT_EN
    logic [IDLE_DIV-1:0] hb_q, hb_d;

    // Counter only runs while the bank stays idle; any departure clears it.
    always_comb begin
        hb_d = '0;
        if (state_q == StIdle && !any_req) hb_d = hb_q + IDLE_DIV'(1);
    end

    assign idle_led = LED_W'(hb_q[IDLE_DIV-1]);

    always_ff @(posedge clk_i) begin
        if (!resetn_i) hb_q <= '0;
        else           hb_q <= hb_d;
    end
`else
    assign idle_led = '0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        led_d   = '0;
        case (state_q)
            StIdle, StGap: begin
                if (any_req) begin
                    state_d = StGrant;
                    owner_d = win_idx;
                    cnt_d   = '0;
                    gnt_d   = win_oh;
                    led_d   = win_pat;
                end else begin
                    state_d = StIdle;
                    if (state_q == StIdle) led_d = idle_led;
                end
            end
            StGrant: begin
                if (!req_i[owner_q] || (cnt_q == HoldMax && others_req)) begin
                    state_d = StGap;
                    last_d  = owner_q;
                end else begin
                    gnt_d = own_oh;
                    led_d = own_pat;
                    if (cnt_q != HoldMax) cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= StIdle;
            last_q  <= LastRst;
            owner_q <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            led_q   <= led_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign led_o  = led_q;
    assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_led_arbiter.sv
// Scoreboard bench for led_arbiter: stimulus pushes expected outputs, a monitor pops and compares.
module tb_led_arbiter;

    logic       clk;
    logic       resetn;
    logic [1:0] req;
    logic [5:0] pattern;
    logic [1:0] gnt;
    logic [2:0] led;
    logic       busy;

    led_arbiter #(
        .NUM_REQ    (2),
        .LED_W      (3),
        .HOLD_CYCLES(4),
        .IDLE_DIV   (3)
    ) dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .req_i    (req),
        .pattern_i(pattern),
        .gnt_o    (gnt),
        .led_o    (led),
        .busy_o   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] gnt;
        logic [2:0] led;
        logic       busy;
        string      nm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose target cycle has arrived.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            n_cmp++;
            if (mon_e.cyc != cyc || gnt !== mon_e.gnt || led !== mon_e.led
                || busy !== mon_e.busy) begin
                n_bad++;
                $display("FAIL %s cyc=%0d: got gnt=%b led=%b busy=%b, want gnt=%b led=%b busy=%b",
                         mon_e.nm, cyc, gnt, led, busy, mon_e.gnt, mon_e.led, mon_e.busy);
            end
        end
    end

    // Drive inputs away from the active edge and queue the outputs expected after it.
    task automatic step(input logic rn, input logic [1:0] r, input logic [2:0] p0,
                        input logic [2:0] p1, input logic [1:0] eg, input logic [2:0] el,
                        input logic eb, input string nm);
        exp_t e;
        @(negedge clk);
        resetn  = rn;
        req     = r;
        pattern = {p1, p0};
        e.cyc   = cyc + 1;
        e.gnt   = eg;
        e.led   = el;
        e.busy  = eb;
        e.nm    = nm;
        sb.push_back(e);
    endtask

    function automatic logic [2:0] hb_exp(input int k);
`ifdef LED_ARB_HEARTBEAT_EN
        return 3'(((k - 1) >> 2) & 1);
`else
        return 3'(k & 0);
`endif
    endfunction

    initial begin
        resetn  = 1'b0;
        req     = 2'b11;
        pattern = 6'b110_101;

        step(0, 2'b11, 3'b101, 3'b110, 2'b00, 3'b000, 0, "reset0");
        step(0, 2'b11, 3'b101, 3'b110, 2'b00, 3'b000, 0, "reset1");

        step(1, 2'b01, 3'b101, 3'b110, 2'b01, 3'b101, 1, "single_grant");
        step(1, 2'b01, 3'b010, 3'b110, 2'b01, 3'b010, 1, "pattern_change");
        step(1, 2'b00, 3'b010, 3'b110, 2'b00, 3'b000, 1, "early_release_gap");
        step(1, 2'b00, 3'b010, 3'b110, 2'b00, 3'b000, 0, "early_release_idle");
        step(1, 2'b10, 3'b010, 3'b110, 2'b10, 3'b110, 1, "req1_grant");
        step(1, 2'b10, 3'b010, 3'b110, 2'b10, 3'b110, 1, "req1_hold");
        step(1, 2'b00, 3'b010, 3'b110, 2'b00, 3'b000, 1, "req1_gap");
        step(1, 2'b00, 3'b010, 3'b110, 2'b00, 3'b000, 0, "req1_idle");

        // Contention from IDLE with last=1: requester 0 wins first.
        for (int k = 0; k < 5; k++)
            step(1, 2'b11, 3'b101, 3'b110, 2'b01, 3'b101, 1, "cont_g0");
        step(1, 2'b11, 3'b101, 3'b110, 2'b00, 3'b000, 1, "cont_gap0");
        for (int k = 0; k < 5; k++)
            step(1, 2'b11, 3'b101, 3'b110, 2'b10, 3'b110, 1, "cont_g1");
        step(1, 2'b11, 3'b101, 3'b110, 2'b00, 3'b000, 1, "cont_gap1");
        for (int k = 0; k < 5; k++)
            step(1, 2'b11, 3'b111, 3'b110, 2'b01, 3'b111, 1, "cont_g0b");
        step(1, 2'b11, 3'b111, 3'b110, 2'b00, 3'b000, 1, "cont_gap2");
        step(1, 2'b11, 3'b111, 3'b011, 2'b10, 3'b011, 1, "cont_g1b");

        step(0, 2'b11, 3'b111, 3'b011, 2'b00, 3'b000, 0, "reset_mid");
        step(1, 2'b11, 3'b001, 3'b011, 2'b01, 3'b001, 1, "post_reset_g0");
        step(1, 2'b00, 3'b001, 3'b011, 2'b00, 3'b000, 1, "drop_gap");
        step(1, 2'b00, 3'b001, 3'b011, 2'b00, 3'b000, 0, "drop_idle");

        for (int k = 1; k <= 32; k++)
            step(1, 2'b00, 3'b001, 3'b011, 2'b00, hb_exp(k), 0, "heartbeat");

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations never compared, required 0", sb.size());
            n_bad += sb.size();
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_arbiter.md
# led_arbiter

Shares the board LED bank between several RTL requesters (user logic, block-design status taps) using round-robin arbitration with a minimum hold time. It sits between the requesting modules and the top-level LED pins, in the clk/resetn domain. It drives the bank from the current grantee's pattern and inserts a one-cycle blank on every handoff.

## Interface
- NUM_REQ, 2: number of requesters (≥2).
- LED_W, 3: LED bank width.
- HOLD_CYCLES, 16: minimum grant length, in cycles, before preemption (≥1).
- IDLE_DIV, 24: heartbeat divider exponent; only used with LED_ARB_HEARTBEAT_EN.

- clk  in  1  single clock; all logic is on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level.
- pattern  in  NUM_REQ*LED_W  requester i pattern at bits [i*LED_W +: LED_W].
- gnt  out  NUM_REQ  one-hot grant, registered; all-zero when nobody owns the bank.
- led  out  LED_W  registered LED drive.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, GRANT, GAP.
- Round-robin pointer `last` = index of most recent grantee. Winner = first i with req[i]=1, scanning last+1, last+2, … modulo NUM_REQ.
- IDLE: if any req is set, go to GRANT. Load gnt with the winner one-hot and clear hold counter `cnt`. Otherwise stay.
- GRANT (owner c):
  - req[c]=0: go to GAP.
  - cnt==HOLD_CYCLES and any req[j≠c]=1: go to GAP (preemption).
  - otherwise stay. cnt increments and saturates at HOLD_CYCLES.
- GAP: lasts exactly one cycle with gnt=0 and led=0. `last` is set to c on entry. Next state is GRANT to the winner if any req is set (cnt cleared), else IDLE.
- When only the owner is requesting, it keeps the grant indefinitely after the hold expires.
- led in GRANT: registered copy of the owner's pattern, reloaded every cycle. It is loaded from the winner's pattern on the same edge that asserts gnt.
- led in IDLE: 0, except when the heartbeat is enabled (see Configuration).
- cnt width is clog2(HOLD_CYCLES+1).
- Simultaneous drop of req[c] and a new request from another requester: the handoff still goes through GAP.
- Reset values: gnt=0, led=0, busy=0, state=IDLE, cnt=0, heartbeat counter=0, last=NUM_REQ-1 (so the first scan starts at index 0).
- Reset asserted mid-grant: all of the above values apply on the next edge, with no gap cycle.

## Timing
- req sampled at edge n in IDLE: gnt and led are valid after edge n (1-cycle latency).
- A grant lasts at least HOLD_CYCLES+1 cycles when it ends by preemption.
- Owner drops req sampled at edge n: gnt=0 after edge n; the next grant is no earlier than after edge n+1.
- A pattern change by the owner appears on led one edge later.
- gnt is never multi-hot. gnt never moves between requesters without an intervening all-zero cycle.

## Configuration
- LED_ARB_HEARTBEAT_EN defined:
  - a free-running IDLE_DIV-bit counter runs only in IDLE and clears on leaving IDLE;
  - in IDLE, led = {(LED_W-1){0}, counter[IDLE_DIV-1]}, so led[0] toggles every 2^(IDLE_DIV-1) cycles;
  - GRANT and GAP behaviour is unchanged.
- Not defined: the counter is absent and led=0 in IDLE.

## Test plan
Bench parameters: NUM_REQ=2, LED_W=3, HOLD_CYCLES=4, IDLE_DIV=3.
- Reset: resetn=0 for 2 edges with req=11 → gnt=00, led=000, busy=0 throughout.
- Single request: req=01, pattern0=101 → after 1 edge gnt=01, led=101, busy=1. Change pattern0 to 010 → led=010 one edge later.
- Contention: req=11 held from IDLE → gnt=01 for 5 cycles, then 00 for 1 cycle, then 10 for 5 cycles, then 00, then 01, repeating. led=000 on every gap cycle.
- Early release: req0 dropped on the 2nd grant cycle with req1=0 → gap of 1 cycle, then IDLE, busy=0. Raising req1 then gives gnt=10 after 1 edge.
- Reset mid-operation: resetn=0 during gnt=10 → gnt=00, led=000 after that edge. On release with req=11, the first grant is 01.
- Heartbeat: sit in IDLE for 32 cycles → with LED_ARB_HEARTBEAT_EN, led toggles 000↔001 every 4 cycles; without it, led stays 000.
